// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate defaults, bit-period derivation and TX state encoding.
// The receiver imports this package as well, so both ends agree on timing.
package uart_pkg;

    localparam int DEFAULT_BAUD_RATE     = 9600;
    localparam int DEFAULT_CLOCK_FREQ_HZ = 12000000;
    localparam int DEFAULT_FIFO_DEPTH    = 4;
    localparam int DATA_BITS             = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Clocks per line bit; integer division truncates any fractional remainder.
    function automatic int bit_period(input int clock_freq_hz, input int baud_rate);
        return clock_freq_hz / baud_rate;
    endfunction

    // Width of the bit-period counter; never narrower than one bit.
    function automatic int cnt_width(input int period);
        return (period <= 1) ? 1 : $clog2(period);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer: circular store with power-of-two depth and an occupancy counter
// one bit wider than the pointers so that full and empty never alias.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; a cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: a byte FIFO feeds a four-state framer whose line output
// comes straight from a flip-flop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE     = DEFAULT_BAUD_RATE,
    parameter int CLOCK_FREQ_HZ = DEFAULT_CLOCK_FREQ_HZ,
    parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int BIT_PERIOD = bit_period(CLOCK_FREQ_HZ, BAUD_RATE);
    localparam int CW         = cnt_width(BIT_PERIOD);
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_PERIOD - 1);

    tx_state_e  state;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic [7:0] fifo_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       bit_done;

    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign bit_done = (cnt == LAST_CNT);
    assign in_ready = !fifo_full;
    assign busy     = (state != IDLE) || !fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // tx is loaded one edge ahead of each bit so the line changes exactly on bit boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                    if (!fifo_empty) begin
                        shreg <= fifo_data;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast instance (10 clocks/bit) for FIFO and framing
// scenarios, plus a default-parameter instance for the 1250-clock bit timing.
module tb_uart_tx;

    localparam int BPF = 10;            // 100000 / 9600 truncated
    localparam int BPD = 1250;          // 12000000 / 9600
    localparam int FR  = 10 * BPF + 1;  // frame plus one idle cycle

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data, in_data_d;
    logic       in_valid, in_valid_d;
    logic       in_ready, tx, busy;
    logic       in_ready_d, tx_d, busy_d;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.BAUD_RATE(9600), .CLOCK_FREQ_HZ(100000), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy)
    );

    uart_tx u_dut_def (
        .clk(clk), .rst(rst), .in_data(in_data_d), .in_valid(in_valid_d),
        .in_ready(in_ready_d), .tx(tx_d), .busy(busy_d)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic line(input bit sel);
        return sel ? tx_d : tx;
    endfunction

    // Waits for a falling edge, then checks every sample of all ten bits and the idle cycle after.
    task automatic get_frame(input string tag, input bit sel, input logic [7:0] exp,
                             input int bp, output int start);
        int t;
        int good;
        logic [9:0] bits;
        t = 0;
        start = -1;
        bits = {1'b1, exp, 1'b0};
        @(negedge clk);
        while (line(sel) !== 1'b0 && t < 20 * bp + 200) begin
            @(negedge clk);
            t++;
        end
        if (line(sel) !== 1'b0) begin
            chk({tag, " start timeout"}, 0, 1);
            return;
        end
        start = cyc;
        for (int i = 0; i < 10; i++) begin
            good = 0;
            for (int c = 0; c < bp; c++) begin
                if (line(sel) === bits[i]) good++;
                @(negedge clk);
            end
            chk($sformatf("%s bit%0d samples", tag, i), good, bp);
        end
        chk({tag, " idle after stop"}, line(sel), 1);
    endtask

    // Offers one byte to the fast instance; acc is the edge on which it was taken.
    task automatic push(input logic [7:0] d, output int acc);
        int t;
        t = 0;
        acc = -1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("push accept timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    logic [7:0] b2b_b [4] = '{8'h31, 8'h32, 8'h33, 8'h34};
    logic [7:0] bp_b  [9] = '{8'hA0, 8'h01, 8'hFE, 8'h80, 8'h7F, 8'hC3, 8'h5A, 8'h00, 8'hFF};
    logic [7:0] hf_b  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int acc [9];
    int st  [9];
    int acc_d, s_d, a, lows;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;  in_data = 8'h00;
        in_valid_d = 1'b0; in_data_d = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset tx", tx, 1);
        chk("reset in_ready", in_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset tx def", tx_d, 1);
        chk("reset in_ready def", in_ready_d, 1);
        chk("reset busy def", busy_d, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte at default rate
        fork
            begin
                @(negedge clk);
                in_valid_d = 1'b1;
                in_data_d  = 8'h55;
                acc_d = cyc + 1;
                @(posedge clk);
                #1 in_valid_d = 1'b0;
                repeat (2) @(negedge clk);
                chk("single busy mid", busy_d, 1);
            end
            get_frame("single55", 1'b1, 8'h55, BPD, s_d);
        join
        chk("single latency", s_d, acc_d + 1);
        chk("single busy end", busy_d, 0);

        // Back-to-back pushes
        fork
            for (int k = 0; k < 4; k++) push(b2b_b[k], acc[k]);
            for (int k = 0; k < 4; k++) get_frame($sformatf("b2b%0d", k), 1'b0, b2b_b[k], BPF, st[k]);
        join
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("b2b accept%0d", k), acc[k], acc[0] + k);
            chk($sformatf("b2b gap%0d", k), st[k], st[k-1] + FR);
        end
        chk("b2b latency", st[0], acc[0] + 1);
        chk("b2b busy end", busy, 0);

        // Backpressure with nine bytes, wrapping the pointers twice
        fork
            for (int k = 0; k < 9; k++) begin
                push(bp_b[k], acc[k]);
                if (k == 4) begin
                    @(negedge clk);
                    chk("bp ready low when full", in_ready, 0);
                end
            end
            for (int k = 0; k < 9; k++) get_frame($sformatf("bp%0d", k), 1'b0, bp_b[k], BPF, st[k]);
        join
        for (int k = 1; k < 5; k++) chk($sformatf("bp accept%0d", k), acc[k], acc[0] + k);
        chk("bp accept5 at frame2 start", acc[5], acc[0] + FR + 2);
        chk("bp accept6 at frame3 start", acc[6], acc[0] + 2 * FR + 2);
        for (int k = 1; k < 9; k++) chk($sformatf("bp gap%0d", k), st[k], st[k-1] + FR);
        chk("bp busy end", busy, 0);

        // Simultaneous push and pop with two entries buffered
        fork
            begin
                push(hf_b[0], acc[0]);
                push(hf_b[1], acc[1]);
                push(hf_b[2], acc[2]);
                a = acc[0];
                while (cyc < a + FR - 1) @(negedge clk);
                push(hf_b[3], acc[3]);
                push(hf_b[4], acc[4]);
                push(hf_b[5], acc[5]);
                @(negedge clk);
                chk("hf ready low at four", in_ready, 0);
            end
            for (int k = 0; k < 6; k++) get_frame($sformatf("hf%0d", k), 1'b0, hf_b[k], BPF, st[k]);
        join
        chk("hf push on pop edge", acc[3], st[0] + FR);
        chk("hf accept4", acc[4], acc[3] + 1);
        chk("hf accept5", acc[5], acc[3] + 2);
        for (int k = 1; k < 6; k++) chk($sformatf("hf gap%0d", k), st[k], st[k-1] + FR);

        // Reset during data bit 3 of 0xA5 with 0x99 still buffered
        push(8'hA5, acc[0]);
        push(8'h99, acc[1]);
        while (cyc < acc[0] + 1 + 4 * BPF + 5) @(negedge clk);
        chk("rst pre tx bit3", tx, 0);
        rst = 1'b1;
        #1;
        chk("rst async tx", tx, 1);
        chk("rst async in_ready", in_ready, 1);
        chk("rst async busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fork
            push(8'h0F, acc[2]);
            get_frame("post_rst0F", 1'b0, 8'h0F, BPF, st[0]);
        join
        chk("post rst latency", st[0], acc[2] + 1);
        lows = 0;
        for (int c = 0; c < 3 * FR; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("post rst no extra frame", lows, 0);
        chk("post rst busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
